// File: rtl/lsu_pkg.sv
// Shared LSU definitions: store-queue entry layout, width helpers and the word-compare slice.
package lsu_pkg;

  function automatic int unsigned mask_w(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth < 2) ? 1 : int'($clog2(depth));
  endfunction

  localparam int unsigned LSU_ADDR_W    = 32;
  localparam int unsigned LSU_DATA_W    = 32;
  localparam int unsigned LSU_ROB_PTR_W = 6;
  localparam int unsigned LSU_MASK_W    = mask_w(LSU_DATA_W);

  // Loads and stores are matched on the word address; the byte offset is covered by the mask.
  localparam int unsigned WORD_LSB = 2;
  localparam int unsigned WORD_W   = LSU_ADDR_W - WORD_LSB;

  typedef struct packed {
    logic                     valid;
    logic                     filled;
    logic                     trap;
    logic                     committed;
    logic [LSU_ROB_PTR_W-1:0] rob_ptr;
    logic [LSU_ADDR_W-1:0]    addr;
    logic [LSU_DATA_W-1:0]    data;
    logic [LSU_MASK_W-1:0]    mask;
  } stq_entry_t;

endpackage

// File: rtl/stq_fwd_select.sv
// Picks the youngest set bit of a match vector, with age measured from the queue head.
module stq_fwd_select
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic [DEPTH-1:0]        match,
  input  logic [ptr_w(DEPTH)-1:0] head,
  output logic                    found,
  output logic [ptr_w(DEPTH)-1:0] sel
);

  localparam int unsigned IDX_W = ptr_w(DEPTH);

  logic [IDX_W-1:0] idx;

  // Walk oldest to youngest so the last hit is the youngest store.
  always_comb begin
    found = 1'b0;
    sel   = head;
    idx   = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = IDX_W'(head + IDX_W'(k));
      if (match[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

endmodule

// File: rtl/lsu_store_queue.sv
// In-order LSU store queue: ROB-driven commit, Dcache drain, flush and store-to-load forwarding.
// Define LSU_STQ_FORWARD_EN for real forwarding; otherwise matching loads stall conservatively.
module lsu_store_queue
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_W    = LSU_ADDR_W,
  parameter int unsigned DATA_W    = LSU_DATA_W,
  parameter int unsigned ROB_PTR_W = LSU_ROB_PTR_W
) (
  input  logic                        Clk,
  input  logic                        Rest,
  input  logic                        AllocAble,
  input  logic [ROB_PTR_W-1:0]        AllocRobPtr,
  output logic [ptr_w(DEPTH)-1:0]     AllocPtr,
  output logic                        StoreFull,
  output logic                        StoreEmpty,
  output logic [ptr_w(DEPTH):0]       StoreCount,
  input  logic                        FillAble,
  input  logic [ptr_w(DEPTH)-1:0]     FillPtr,
  input  logic [ADDR_W-1:0]           FillAddr,
  input  logic [DATA_W-1:0]           FillDate,
  input  logic [mask_w(DATA_W)-1:0]   FillMask,
  input  logic                        FillTrap,
  input  logic                        RetireAble,
  output logic                        StoreAble,
  output logic [ADDR_W-1:0]           StoreAddr,
  output logic [DATA_W-1:0]           StoreDate,
  output logic [mask_w(DATA_W)-1:0]   StoreMask,
  input  logic                        StoreBuzy,
  input  logic                        FwdAble,
  input  logic [ADDR_W-1:0]           FwdAddr,
  input  logic [mask_w(DATA_W)-1:0]   FwdMask,
  output logic                        FwdHit,
  output logic [DATA_W-1:0]           FwdDate,
  output logic                        FwdStall,
  input  logic                        LsuStop,
  input  logic                        LsuFLash
);

  localparam int unsigned IDX_W  = ptr_w(DEPTH);
  localparam int unsigned PTR_W  = IDX_W + 1;
  localparam int unsigned MASK_W = mask_w(DATA_W);

  stq_entry_t       ent_q [DEPTH];
  stq_entry_t       ent_d [DEPTH];
  logic [PTR_W-1:0] head_q, commit_q, tail_q;
  logic [PTR_W-1:0] head_d, commit_d, tail_d;
  logic [IDX_W-1:0] head_idx, commit_idx, tail_idx;
  logic             full_c, store_go, trap_drop, pop;
  logic             do_alloc, do_fill, do_retire;

  assign head_idx   = head_q[IDX_W-1:0];
  assign commit_idx = commit_q[IDX_W-1:0];
  assign tail_idx   = tail_q[IDX_W-1:0];

  assign full_c     = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
  assign AllocPtr   = tail_idx;
  assign StoreFull  = full_c;
  assign StoreEmpty = (head_q == tail_q);
  assign StoreCount = tail_q - head_q;

  // Head offer to the Dcache; a trapped store is retired without a bus transfer.
  assign store_go  = ent_q[head_idx].valid & ent_q[head_idx].committed & ent_q[head_idx].filled
                   & ~ent_q[head_idx].trap & ~LsuStop;
  assign trap_drop = ent_q[head_idx].valid & ent_q[head_idx].committed & ent_q[head_idx].trap
                   & ~LsuStop;
  assign pop       = (store_go & ~StoreBuzy) | trap_drop;

  assign StoreAble = store_go;
  assign StoreAddr = ADDR_W'(ent_q[head_idx].addr);
  assign StoreDate = DATA_W'(ent_q[head_idx].data);
  assign StoreMask = MASK_W'(ent_q[head_idx].mask);

  assign do_alloc  = AllocAble & ~full_c & ~LsuFLash;
  assign do_fill   = FillAble & ent_q[FillPtr].valid;
  assign do_retire = RetireAble & (commit_q != tail_q);

  // Next-state for entries and pointers; the order of updates sets event priority.
  always_comb begin
    ent_d    = ent_q;
    head_d   = head_q;
    commit_d = commit_q;
    tail_d   = tail_q;

    if (do_alloc) begin
      ent_d[tail_idx]         = '0;
      ent_d[tail_idx].valid   = 1'b1;
      ent_d[tail_idx].rob_ptr = LSU_ROB_PTR_W'(AllocRobPtr);
      tail_d                  = tail_q + PTR_W'(1);
    end

    if (do_fill) begin
      ent_d[FillPtr].filled = 1'b1;
      ent_d[FillPtr].trap   = FillTrap;
      ent_d[FillPtr].addr   = LSU_ADDR_W'(FillAddr);
      ent_d[FillPtr].data   = LSU_DATA_W'(FillDate);
      ent_d[FillPtr].mask   = LSU_MASK_W'(FillMask);
    end

    if (do_retire) begin
      ent_d[commit_idx].committed = 1'b1;
      commit_d                    = commit_q + PTR_W'(1);
    end

    // Everything the ROB has committed survives, including this cycle's retire.
    if (LsuFLash) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (ent_d[IDX_W'(i)].valid && !ent_d[IDX_W'(i)].committed) begin
          ent_d[IDX_W'(i)].valid = 1'b0;
        end
      end
      tail_d = commit_d;
    end

    if (pop) begin
      ent_d[head_idx] = '0;
      head_d          = head_q + PTR_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      head_q   <= '0;
      commit_q <= '0;
      tail_q   <= '0;
      ent_q    <= '{default: '0};
    end else begin
      head_q   <= head_d;
      commit_q <= commit_d;
      tail_q   <= tail_d;
      ent_q    <= ent_d;
    end
  end

  logic [DEPTH-1:0]  fwd_match;
  logic [DEPTH-1:0]  fwd_pend;
  logic [WORD_W-1:0] fwd_word;

  assign fwd_word = WORD_W'(FwdAddr[ADDR_W-1:WORD_LSB]);

  // Per-entry word match against the load, plus stores whose address is not yet known.
  always_comb begin
    fwd_match = '0;
    fwd_pend  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_match[IDX_W'(i)] = ent_q[IDX_W'(i)].valid & ent_q[IDX_W'(i)].filled
                           & (ent_q[IDX_W'(i)].addr[LSU_ADDR_W-1:WORD_LSB] == fwd_word);
      fwd_pend[IDX_W'(i)]  = ent_q[IDX_W'(i)].valid & ~ent_q[IDX_W'(i)].filled;
    end
  end

`ifdef LSU_STQ_FORWARD_EN
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_cover;

  stq_fwd_select #(
    .DEPTH (DEPTH)
  ) u_fwd_select (
    .match (fwd_match),
    .head  (head_idx),
    .found (sel_found),
    .sel   (sel_idx)
  );

  assign sel_cover = (ent_q[sel_idx].mask & LSU_MASK_W'(FwdMask)) == LSU_MASK_W'(FwdMask);
  assign FwdHit    = FwdAble & ~(|fwd_pend) & sel_found & sel_cover;
  assign FwdStall  = FwdAble & ((|fwd_pend) | (sel_found & ~sel_cover));
  assign FwdDate   = FwdHit ? DATA_W'(ent_q[sel_idx].data) : '0;

  logic unused_bits;
  assign unused_bits = ^{FwdAddr[WORD_LSB-1:0], ent_q[head_idx].rob_ptr};
`else
  assign FwdHit   = 1'b0;
  assign FwdDate  = '0;
  assign FwdStall = FwdAble & ((|fwd_pend) | (|fwd_match));

  logic unused_bits;
  assign unused_bits = ^{FwdAddr[WORD_LSB-1:0], FwdMask, ent_q[head_idx].rob_ptr};
`endif

endmodule

// File: tb/tb_lsu_store_queue.sv
// Self-checking bench for lsu_store_queue: drained stores are checked against a commit-order scoreboard.
`timescale 1ns/1ps
module tb_lsu_store_queue;

  localparam int unsigned DEPTH     = 16;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ROB_PTR_W = 6;
  localparam int unsigned MASK_W    = 4;
  localparam int unsigned IDX_W     = 4;

  logic                 Clk = 1'b0;
  logic                 Rest = 1'b0;
  logic                 AllocAble, FillAble, FillTrap, RetireAble, StoreBuzy;
  logic                 FwdAble, LsuStop, LsuFLash;
  logic [ROB_PTR_W-1:0] AllocRobPtr;
  logic [IDX_W-1:0]     AllocPtr, FillPtr;
  logic                 StoreFull, StoreEmpty, StoreAble, FwdHit, FwdStall;
  logic [IDX_W:0]       StoreCount;
  logic [ADDR_W-1:0]    FillAddr, StoreAddr, FwdAddr;
  logic [DATA_W-1:0]    FillDate, StoreDate, FwdDate;
  logic [MASK_W-1:0]    FillMask, StoreMask, FwdMask;

  lsu_store_queue #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROB_PTR_W(ROB_PTR_W)
  ) dut (
    .Clk(Clk), .Rest(Rest),
    .AllocAble(AllocAble), .AllocRobPtr(AllocRobPtr), .AllocPtr(AllocPtr),
    .StoreFull(StoreFull), .StoreEmpty(StoreEmpty), .StoreCount(StoreCount),
    .FillAble(FillAble), .FillPtr(FillPtr), .FillAddr(FillAddr), .FillDate(FillDate),
    .FillMask(FillMask), .FillTrap(FillTrap), .RetireAble(RetireAble),
    .StoreAble(StoreAble), .StoreAddr(StoreAddr), .StoreDate(StoreDate), .StoreMask(StoreMask),
    .StoreBuzy(StoreBuzy), .FwdAble(FwdAble), .FwdAddr(FwdAddr), .FwdMask(FwdMask),
    .FwdHit(FwdHit), .FwdDate(FwdDate), .FwdStall(FwdStall),
    .LsuStop(LsuStop), .LsuFLash(LsuFLash)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } exp_t;

  exp_t              exp_q[$];
  int                n_checks = 0;
  int                n_fail = 0;
  int                n_drained = 0;
  int                n_able = 0;
  int                m_tail = 0;
  int                m_commit = 0;
  logic [ADDR_W-1:0] m_addr [DEPTH];
  logic [DATA_W-1:0] m_data [DEPTH];
  logic [MASK_W-1:0] m_mask [DEPTH];
  logic              m_trap [DEPTH];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every Dcache transfer must be the next committed store in program order.
  always @(negedge Clk) begin
    if (Rest && StoreAble) n_able <= n_able + 1;
    if (Rest && StoreAble && !StoreBuzy) begin
      if (exp_q.size() == 0) begin
        chk("drain_unexpected", 64'(StoreAddr), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("drain_addr", 64'(StoreAddr), 64'(e.addr));
        chk("drain_data", 64'(StoreDate), 64'(e.data));
        chk("drain_mask", 64'(StoreMask), 64'(e.mask));
      end
      n_drained <= n_drained + 1;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_alloc();
    AllocAble   = 1'b1;
    AllocRobPtr = ROB_PTR_W'(m_tail);
    tick();
    AllocAble   = 1'b0;
    m_tail++;
  endtask

  task automatic do_fill(input logic [IDX_W-1:0] idx, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m, input logic trap);
    FillAble = 1'b1; FillPtr = idx; FillAddr = a; FillDate = d; FillMask = m; FillTrap = trap;
    tick();
    FillAble = 1'b0; FillTrap = 1'b0;
    m_addr[idx] = a; m_data[idx] = d; m_mask[idx] = m; m_trap[idx] = trap;
  endtask

  task automatic push_commit();
    logic [IDX_W-1:0] idx;
    idx = IDX_W'(m_commit);
    if (!m_trap[idx]) exp_q.push_back('{addr: m_addr[idx], data: m_data[idx], mask: m_mask[idx]});
    m_commit++;
  endtask

  task automatic do_retire();
    push_commit();
    RetireAble = 1'b1;
    tick();
    RetireAble = 1'b0;
  endtask

  task automatic do_flush(input logic with_retire, input logic with_alloc);
    LsuFLash = 1'b1; RetireAble = with_retire; AllocAble = with_alloc;
    if (with_retire) push_commit();
    tick();
    LsuFLash = 1'b0; RetireAble = 1'b0; AllocAble = 1'b0;
    m_tail = m_commit;
  endtask

  task automatic lookup(input logic [ADDR_W-1:0] a, input logic [MASK_W-1:0] m);
    FwdAble = 1'b1; FwdAddr = a; FwdMask = m;
    #1;
  endtask

  task automatic wait_empty(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (StoreEmpty) break;
      tick();
    end
    chk(tag, 64'(StoreEmpty), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    int b;
    int d0;
    int a0;
    AllocAble = 0; AllocRobPtr = '0; FillAble = 0; FillPtr = '0; FillAddr = '0; FillDate = '0;
    FillMask = '0; FillTrap = 0; RetireAble = 0; StoreBuzy = 0; FwdAble = 1; FwdAddr = '0;
    FwdMask = '0; LsuStop = 0; LsuFLash = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      m_addr[i] = '0; m_data[i] = '0; m_mask[i] = '0; m_trap[i] = 1'b0;
    end

    #12;
    chk("rst_able",  64'(StoreAble),  64'd0);
    chk("rst_full",  64'(StoreFull),  64'd0);
    chk("rst_empty", 64'(StoreEmpty), 64'd1);
    chk("rst_count", 64'(StoreCount), 64'd0);
    chk("rst_ptr",   64'(AllocPtr),   64'd0);
    chk("rst_hit",   64'(FwdHit),     64'd0);
    chk("rst_stall", 64'(FwdStall),   64'd0);
    FwdAble = 0;
    @(negedge Clk);
    Rest = 1'b1;
    tick();

    // Fill to full; the extra alloc must be refused.
    for (int i = 0; i < int'(DEPTH); i++) do_alloc();
    chk("full_flag",  64'(StoreFull),  64'd1);
    chk("full_count", 64'(StoreCount), 64'd16);
    chk("full_ptr",   64'(AllocPtr),   64'd0);
    chk("full_empty", 64'(StoreEmpty), 64'd0);
    AllocAble = 1'b1;
    tick();
    AllocAble = 1'b0;
    chk("over_count", 64'(StoreCount), 64'd16);
    chk("over_ptr",   64'(AllocPtr),   64'd0);
    lookup(32'h300, 4'hF);
    chk("unfilled_stall", 64'(FwdStall), 64'd1);
    chk("unfilled_hit",   64'(FwdHit),   64'd0);
    FwdAble = 0;
    do_flush(1'b0, 1'b0);
    chk("flush_all_empty", 64'(StoreEmpty), 64'd1);
    chk("flush_all_count", 64'(StoreCount), 64'd0);

    // Commit and drain under Dcache back-pressure.
    StoreBuzy = 1'b1;
    b = m_tail;
    do_alloc();
    do_fill(IDX_W'(b), 32'h100, 32'hAABBCCDD, 4'hF, 1'b0);
    do_retire();
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("hold_able", 64'(StoreAble), 64'd1);
      chk("hold_addr", 64'(StoreAddr), 64'h100);
      chk("hold_data", 64'(StoreDate), 64'hAABBCCDD);
      chk("hold_mask", 64'(StoreMask), 64'hF);
      tick();
    end
    d0 = n_drained;
    StoreBuzy = 1'b0;
    tick();
    chk("drain_empty", 64'(StoreEmpty), 64'd1);
    chk("drain_count", 64'(n_drained - d0), 64'd1);

    // Forwarding: younger full-mask store wins over an older partial one.
    b = m_tail;
    do_alloc();
    do_alloc();
    do_fill(IDX_W'(b),     32'h200, 32'hDEADBEEF, 4'h3, 1'b0);
    do_fill(IDX_W'(b + 1), 32'h200, 32'h11223344, 4'hF, 1'b0);
    lookup(32'h200, 4'hF);
`ifdef LSU_STQ_FORWARD_EN
    chk("fwd_hit",   64'(FwdHit),   64'd1);
    chk("fwd_data",  64'(FwdDate),  64'h11223344);
    chk("fwd_stall", 64'(FwdStall), 64'd0);
`else
    chk("fwd_hit",   64'(FwdHit),   64'd0);
    chk("fwd_data",  64'(FwdDate),  64'd0);
    chk("fwd_stall", 64'(FwdStall), 64'd1);
`endif
    lookup(32'h202, 4'hC);
`ifdef LSU_STQ_FORWARD_EN
    chk("fwd_word_hit", 64'(FwdHit), 64'd1);
`else
    chk("fwd_word_hit", 64'(FwdHit), 64'd0);
`endif
    lookup(32'h300, 4'hF);
    chk("miss_hit",   64'(FwdHit),   64'd0);
    chk("miss_stall", 64'(FwdStall), 64'd0);
    FwdAble = 0;
    do_flush(1'b0, 1'b0);
    chk("fwd_flush_empty", 64'(StoreEmpty), 64'd1);

    // Partial coverage stalls, as does any store with an unknown address.
    b = m_tail;
    do_alloc();
    do_fill(IDX_W'(b), 32'h200, 32'h55667788, 4'h3, 1'b0);
    lookup(32'h200, 4'hC);
    chk("partial_stall", 64'(FwdStall), 64'd1);
    chk("partial_hit",   64'(FwdHit),   64'd0);
    FwdAble = 0;
    do_alloc();
    lookup(32'h300, 4'hF);
    chk("pend_stall", 64'(FwdStall), 64'd1);
    chk("pend_hit",   64'(FwdHit),   64'd0);
    FwdAble = 0;
    do_flush(1'b0, 1'b0);
    chk("partial_flush_empty", 64'(StoreEmpty), 64'd1);

    // Flush with simultaneous retire and alloc.
    LsuStop = 1'b1;
    b = m_tail;
    for (int k = 0; k < 4; k++) do_alloc();
    for (int k = 0; k < 4; k++)
      do_fill(IDX_W'(b + k), 32'h400 + 32'(4 * k), 32'hC0DE0000 + 32'(k), 4'hF, 1'b0);
    do_retire();
    do_retire();
    do_flush(1'b1, 1'b1);
    chk("flush_count", 64'(StoreCount), 64'd3);
    chk("flush_ptr",   64'(AllocPtr),   64'(IDX_W'(b + 3)));
    d0 = n_drained;
    LsuStop = 1'b0;
    wait_empty("flush_drain_empty", 20);
    chk("flush_drained", 64'(n_drained - d0), 64'd3);
    chk("flush_sb_left", 64'(exp_q.size()), 64'd0);

    // A committed trapped store leaves without ever being offered.
    a0 = n_able;
    b = m_tail;
    do_alloc();
    do_fill(IDX_W'(b), 32'h500, 32'hBADBAD00, 4'hF, 1'b1);
    do_retire();
    repeat (4) tick();
    chk("trap_empty", 64'(StoreEmpty), 64'd1);
    chk("trap_never_able", 64'(n_able - a0), 64'd0);

    // Asynchronous reset in the middle of a pending transfer.
    StoreBuzy = 1'b1;
    b = m_tail;
    for (int k = 0; k < 3; k++) do_alloc();
    do_fill(IDX_W'(b),     32'h700, 32'h01020304, 4'hF, 1'b0);
    do_fill(IDX_W'(b + 1), 32'h704, 32'h05060708, 4'hF, 1'b0);
    do_retire();
    @(negedge Clk);
    chk("pre_rst_able", 64'(StoreAble), 64'd1);
    exp_q.delete();
    #2;
    Rest = 1'b0;
    FwdAble = 1'b1; FwdAddr = 32'h300; FwdMask = 4'hF;
    #1;
    chk("arst_able",  64'(StoreAble),  64'd0);
    chk("arst_empty", 64'(StoreEmpty), 64'd1);
    chk("arst_full",  64'(StoreFull),  64'd0);
    chk("arst_count", 64'(StoreCount), 64'd0);
    chk("arst_ptr",   64'(AllocPtr),   64'd0);
    chk("arst_hit",   64'(FwdHit),     64'd0);
    chk("arst_stall", 64'(FwdStall),   64'd0);
    FwdAble = 1'b0;
    StoreBuzy = 1'b0;
    m_tail = 0;
    m_commit = 0;
    @(negedge Clk);
    Rest = 1'b1;
    tick();

    // Queue is usable again after reset.
    d0 = n_drained;
    do_alloc();
    do_fill(IDX_W'(0), 32'h600, 32'h0BADF00D, 4'h5, 1'b0);
    do_retire();
    wait_empty("post_rst_empty", 10);
    chk("post_rst_drained", 64'(n_drained - d0), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
